// File: rtl/key_code_encoder.sv
// Button edge detector, priority serialiser and code FIFO for the key path.
// Define KEY_ENC_RELEASE_EN to also emit release codes (press code | 8'h80).
module key_code_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    btn_in,
    output logic [7:0]                    key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    function automatic logic [7:0] press_code(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0: c = 8'h01;
            3'd1: c = 8'h02;
            3'd2: c = 8'h05;
            3'd3: c = 8'h06;
            3'd4: c = 8'h07;
            3'd5: c = 8'h08;
            3'd6: c = 8'h09;
            3'd7: c = 8'h0A;
        endcase
        return c;
    endfunction

    logic [7:0]    btn_prev;
    logic [7:0]    press;
    logic [7:0]    pend_p;
    logic [7:0]    srv_p;
    logic          p_any;
    logic [2:0]    p_idx;
    logic          has_space;
    logic          sel_valid;
    logic [7:0]    sel_code;
    logic          ov_hit;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];

`ifdef KEY_ENC_RELEASE_EN
    logic [7:0]    rels;
    logic [7:0]    pend_r;
    logic [7:0]    srv_r;
    logic          r_any;
    logic [2:0]    r_idx;

    assign rels = ~btn_in & btn_prev;

    always_comb begin
        r_any = 1'b0;
        r_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_r[i]) begin
                r_any = 1'b1;
                r_idx = 3'(i);
            end
        end
    end
`endif

    assign press = btn_in & ~btn_prev;

    // Descending scan so the lowest pending index wins.
    always_comb begin
        p_any = 1'b0;
        p_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_p[i]) begin
                p_any = 1'b1;
                p_idx = 3'(i);
            end
        end
    end

    assign has_space = fifo_count < FULL;

    // Presses always outrank releases, keeping press-before-release per key.
    always_comb begin
        srv_p     = 8'h00;
        sel_valid = 1'b0;
        sel_code  = 8'h00;
`ifdef KEY_ENC_RELEASE_EN
        srv_r     = 8'h00;
`endif
        if (has_space) begin
            if (p_any) begin
                srv_p[p_idx] = 1'b1;
                sel_valid    = 1'b1;
                sel_code     = press_code(p_idx);
            end
`ifdef KEY_ENC_RELEASE_EN
            else if (r_any) begin
                srv_r[r_idx] = 1'b1;
                sel_valid    = 1'b1;
                sel_code     = press_code(r_idx) | 8'h80;
            end
`endif
        end
    end

`ifdef KEY_ENC_RELEASE_EN
    assign ov_hit = |(press & pend_p & ~srv_p) |
                    |(rels & pend_r & ~srv_r);
`else
    assign ov_hit = |(press & pend_p & ~srv_p);
`endif

    assign push      = sel_valid;
    assign key_valid = fifo_count != '0;
    assign pop       = key_valid & key_ready;
    assign key_code  = key_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev   <= 8'h00;
            pend_p     <= 8'h00;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            btn_prev <= btn_in;
            pend_p   <= (pend_p & ~srv_p) | press;
            if (ov_hit) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

`ifdef KEY_ENC_RELEASE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 8'h00;
        end else begin
            pend_r <= (pend_r & ~srv_r) | rels;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sel_code;
        end
    end

endmodule

// File: tb/tb_key_code_encoder.sv
// Bench for key_code_encoder: directed scenarios plus random button traffic
// compared every cycle against a queue-based reference model.
module tb_key_code_encoder;

    localparam int DEPTH = 4;
`ifdef KEY_ENC_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] btn_in;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] fifo_count;
    logic       overflow;

    key_code_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    logic [7:0] tab [8] = '{8'h01, 8'h02, 8'h05, 8'h06,
                            8'h07, 8'h08, 8'h09, 8'h0A};
    logic [7:0] m_prev;
    logic [7:0] m_pp;
    logic [7:0] m_rp;
    bit         m_ovf;
    logic [7:0] m_q [$];
    logic [7:0] obs [$];
    logic [7:0] exp_l [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: pending sets of buttons, a code queue, one event per cycle.
    task automatic model_step(input logic [7:0] b, input logic rdy,
                              input logic rs);
        int sp;
        int sr;
        bit room;
        if (rs) begin
            m_q.delete();
            m_pp   = 8'h00;
            m_rp   = 8'h00;
            m_ovf  = 1'b0;
            m_prev = 8'h00;
        end else begin
            sp   = -1;
            sr   = -1;
            room = m_q.size() < DEPTH;
            for (int i = 0; i < 8; i++) begin
                if (room && sp < 0 && m_pp[i]) sp = i;
            end
            for (int i = 0; i < 8; i++) begin
                if (REL && room && sp < 0 && sr < 0 && m_rp[i]) sr = i;
            end
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (sp >= 0) begin
                m_q.push_back(tab[sp]);
                m_pp[sp] = 1'b0;
            end
            if (sr >= 0) begin
                m_q.push_back(tab[sr] | 8'h80);
                m_rp[sr] = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                if (b[i] && !m_prev[i]) begin
                    if (m_pp[i]) m_ovf = 1'b1;
                    m_pp[i] = 1'b1;
                end
                if (REL && !b[i] && m_prev[i]) begin
                    if (m_rp[i]) m_ovf = 1'b1;
                    m_rp[i] = 1'b1;
                end
            end
            m_prev = b;
        end
    endtask

    task automatic cycle(input logic [7:0] b, input logic rdy,
                         input logic rs);
        btn_in    = b;
        key_ready = rdy;
        rst       = rs;
        if (!rs && rdy && key_valid) obs.push_back(key_code);
        @(posedge clk);
        model_step(b, rdy, rs);
        #1;
        check("valid", 32'(key_valid), 32'(m_q.size() != 0));
        check("code", 32'(key_code),
              (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check("count", 32'(fifo_count), 32'(m_q.size()));
        check("ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(obs.size()), 32'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++) begin
            check(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hDEAD,
                  32'(exp_l[i]));
        end
    endtask

    task automatic idle(input int n, input logic [7:0] b, input logic rdy);
        for (int i = 0; i < n; i++) cycle(b, rdy, 1'b0);
    endtask

    logic [7:0] rb;
    logic       rr;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        btn_in    = 8'h00;
        key_ready = 1'b1;
        rst       = 1'b1;
        m_prev    = 8'h00;
        m_pp      = 8'h00;
        m_rp      = 8'h00;
        m_ovf     = 1'b0;

        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        check("rst_code", 32'(key_code), 32'h00);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single UP press held for 10 cycles.
        cycle(8'h00, 1'b1, 1'b0);
        obs.delete();
        cycle(8'h04, 1'b1, 1'b0);
        check("lat_k_valid", 32'(key_valid), 32'd0);
        cycle(8'h04, 1'b1, 1'b0);
        check("lat_k1_valid", 32'(key_valid), 32'd1);
        check("lat_k1_code", 32'(key_code), 32'h05);
        idle(8, 8'h04, 1'b1);
        idle(6, 8'h00, 1'b1);
        exp_l = '{8'h05};
        if (REL) exp_l.push_back(8'h85);
        check_seq("up_seq");

        // Three simultaneous presses.
        obs.delete();
        cycle(8'hC1, 1'b1, 1'b0);
        cycle(8'hC1, 1'b1, 1'b0);
        check("sim_c0", 32'(key_code), 32'h01);
        cycle(8'hC1, 1'b1, 1'b0);
        check("sim_c1", 32'(key_code), 32'h09);
        cycle(8'hC1, 1'b1, 1'b0);
        check("sim_c2", 32'(key_code), 32'h0A);
        idle(3, 8'hC1, 1'b1);
        idle(8, 8'h00, 1'b1);
        exp_l = '{8'h01, 8'h09, 8'h0A};
        if (REL) begin
            exp_l.push_back(8'h81);
            exp_l.push_back(8'h89);
            exp_l.push_back(8'h8A);
        end
        check_seq("sim_seq");

        // All eight with a stalled consumer, then full+pop, then drain.
        obs.delete();
        idle(6, 8'hFF, 1'b0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_head", 32'(key_code), 32'h01);
        cycle(8'hFF, 1'b1, 1'b0);
        check("fullpop_cnt", 32'(fifo_count), 32'd3);
        cycle(8'hFF, 1'b0, 1'b0);
        check("refill_cnt", 32'(fifo_count), 32'd4);
        idle(10, 8'hFF, 1'b1);
        check("all8_ovf", 32'(overflow), 32'd0);
        exp_l = '{8'h01, 8'h02, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A};
        check_seq("all8_seq");
        idle(14, 8'h00, 1'b1);

        // Coalesced A press while the FIFO is full.
        obs.delete();
        idle(6, 8'h0F, 1'b0);
        cycle(8'h4F, 1'b0, 1'b0);
        cycle(8'h0F, 1'b0, 1'b0);
        cycle(8'h4F, 1'b0, 1'b0);
        check("coal_ovf", 32'(overflow), 32'd1);
        idle(2, 8'h4F, 1'b0);
        check("coal_count", 32'(fifo_count), 32'd4);
        idle(10, 8'h4F, 1'b1);
        check("coal_sticky", 32'(overflow), 32'd1);
        exp_l = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h09};
        if (REL) exp_l.push_back(8'h89);
        check_seq("coal_seq");
        idle(10, 8'h00, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);

        // Reset with codes queued and B held.
        cycle(8'h00, 1'b0, 1'b0);
        idle(5, 8'h07, 1'b0);
        check("preq_count", 32'(fifo_count), 32'd3);
        cycle(8'h07, 1'b0, 1'b1);
        check("flush_valid", 32'(key_valid), 32'd0);
        check("flush_count", 32'(fifo_count), 32'd0);
        cycle(8'h01, 1'b0, 1'b0);
        check("post_k", 32'(key_valid), 32'd0);
        cycle(8'h01, 1'b0, 1'b0);
        check("post_valid", 32'(key_valid), 32'd1);
        check("post_code", 32'(key_code), 32'h01);
        idle(3, 8'h01, 1'b1);
        idle(4, 8'h00, 1'b1);

        // Random traffic.
        rb = 8'h00;
        rr = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rb = rb ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) rr = ~rr;
            cycle(rb, rr & ($urandom_range(0, 3) != 0), $urandom_range(0, 499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
